loopback_ctrl: RTL and testbench

Sequencer for the loopback sample datapath. It takes a start command with a line count and read/write base addresses, then issues line read requests to host memory. Returned read data is pushed into the loopback FIFO. Lines are popped from the FIFO and issued as write requests. A credit scheme keeps the FIFO from overflowing. The block sits between the CCI-P request/response channel logic and the loopback FIFO, and reports busy/done to the CSR block.

---
 rtl/hc_pkg.sv | 14 +
 rtl/loopback_ctrl_if.sv | 45 ++++
 rtl/loopback_ctrl.sv | 158 +++++++++++++++
 tb/tb_loopback_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hc_pkg.sv
// Shared types and width defaults for the loopback sample datapath.
package hc_pkg;

  localparam int unsigned HC_ADDR_WIDTH = 42;
  localparam int unsigned HC_DATA_WIDTH = 512;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/loopback_ctrl_if.sv
// Request/response channel and loopback FIFO signals seen by loopback_ctrl.
// master = sequencer side, slave = host channel / FIFO side.
interface loopback_ctrl_if
  import hc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = HC_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = HC_ADDR_WIDTH
);

  logic                  rd_req_valid;
  logic [ADDR_WIDTH-1:0] rd_req_addr;
  logic                  rd_almfull;
  logic                  rd_rsp_valid;

  logic                  fifo_enq_en;
  logic                  fifo_not_full;
  logic                  fifo_deq_en;
  logic                  fifo_not_empty;
  logic [DATA_WIDTH-1:0] fifo_deq_data;

  logic                  wr_req_valid;
  logic [ADDR_WIDTH-1:0] wr_req_addr;
  logic [DATA_WIDTH-1:0] wr_req_data;
  logic                  wr_almfull;
  logic                  wr_rsp_valid;

  modport master (
    output rd_req_valid, rd_req_addr,
    input  rd_almfull, rd_rsp_valid,
    output fifo_enq_en, fifo_deq_en,
    input  fifo_not_full, fifo_not_empty, fifo_deq_data,
    output wr_req_valid, wr_req_addr, wr_req_data,
    input  wr_almfull, wr_rsp_valid
  );

  modport slave (
    input  rd_req_valid, rd_req_addr,
    output rd_almfull, rd_rsp_valid,
    input  fifo_enq_en, fifo_deq_en,
    output fifo_not_full, fifo_not_empty, fifo_deq_data,
    input  wr_req_valid, wr_req_addr, wr_req_data,
    output wr_almfull, wr_rsp_valid
  );

endinterface

// File: rtl/loopback_ctrl.sv
// Loopback sequencer: credit-limited line reads into the loopback FIFO, FIFO pops
// issued as line writes. Define LOOPBACK_CTRL_STATS_EN for cycle/stall statistics.
module loopback_ctrl
  import hc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = HC_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_WIDTH = HC_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           num_lines,
  input  logic [ADDR_WIDTH-1:0] rd_base,
  input  logic [ADDR_WIDTH-1:0] wr_base,
  loopback_ctrl_if.master       bus,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow_err,
  output logic [31:0]           cycle_count,
  output logic [31:0]           stall_count
);

  localparam int unsigned CREDIT_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(FIFO_DEPTH - 1);

  state_t                state;
  logic [31:0]           lines_r;
  logic [ADDR_WIDTH-1:0] rd_base_r;
  logic [ADDR_WIDTH-1:0] wr_base_r;
  logic [31:0]           rd_issued;
  logic [31:0]           wr_issued;
  logic [31:0]           wr_acked;
  logic [31:0]           wr_acked_next;
  logic [CREDIT_W-1:0]   credit;

  logic active;
  logic accept;
  logic rd_pending;
  logic rd_issue;
  logic wr_issue;

  assign active     = (state == ST_RUN) || (state == ST_DRAIN);
  assign accept     = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign rd_pending = (state == ST_RUN) && (rd_issued < lines_r);
  assign rd_issue   = rd_pending && !bus.rd_almfull && (credit != '0);
  assign wr_issue   = active && bus.fifo_not_empty && !bus.wr_almfull && (wr_issued < lines_r);

  assign bus.fifo_deq_en = wr_issue;
  assign bus.fifo_enq_en = bus.rd_rsp_valid;

  // Look-ahead ack count lets DONE follow the final write response by one cycle.
  always_comb begin
    wr_acked_next = wr_acked;
    if (active && bus.wr_rsp_valid) wr_acked_next = wr_acked + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) state <= (num_lines == '0) ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          if (rd_issued == lines_r) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (wr_acked_next == lines_r) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lines_r   <= '0;
      rd_base_r <= '0;
      wr_base_r <= '0;
      rd_issued <= '0;
      wr_issued <= '0;
      wr_acked  <= '0;
      credit    <= '0;
    end else if (accept) begin
      lines_r   <= num_lines;
      rd_base_r <= rd_base;
      wr_base_r <= wr_base;
      rd_issued <= '0;
      wr_issued <= '0;
      wr_acked  <= '0;
      credit    <= CREDIT_MAX;
    end else begin
      if (rd_issue) rd_issued <= rd_issued + 32'd1;
      if (wr_issue) wr_issued <= wr_issued + 32'd1;
      wr_acked <= wr_acked_next;
      if (rd_issue && !wr_issue) begin
        credit <= credit - 1'b1;
      end else if (wr_issue && !rd_issue && (credit != CREDIT_MAX)) begin
        credit <= credit + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rd_req_valid <= 1'b0;
      bus.rd_req_addr  <= '0;
      bus.wr_req_valid <= 1'b0;
      bus.wr_req_addr  <= '0;
      bus.wr_req_data  <= '0;
    end else begin
      bus.rd_req_valid <= rd_issue;
      bus.wr_req_valid <= wr_issue;
      if (rd_issue) bus.rd_req_addr <= rd_base_r + ADDR_WIDTH'(rd_issued);
      if (wr_issue) begin
        bus.wr_req_addr <= wr_base_r + ADDR_WIDTH'(wr_issued);
        bus.wr_req_data <= bus.fifo_deq_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      overflow_err <= 1'b0;
    end else if (bus.rd_rsp_valid && !bus.fifo_not_full) begin
      overflow_err <= 1'b1;
    end
  end

  assign busy = active;
  assign done = (state == ST_DONE);

`ifdef LOOPBACK_CTRL_STATS_EN
  logic [31:0] cycle_r;
  logic [31:0] stall_r;

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      cycle_r <= '0;
      stall_r <= '0;
    end else begin
      if (active && (cycle_r != '1)) cycle_r <= cycle_r + 32'd1;
      if (rd_pending && ((credit == '0) || bus.rd_almfull) && (stall_r != '1)) begin
        stall_r <= stall_r + 32'd1;
      end
    end
  end

  assign cycle_count = cycle_r;
  assign stall_count = stall_r;
`else
  assign cycle_count = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_loopback_ctrl.sv
// Directed + randomized bench for loopback_ctrl with a queue-based host memory and FIFO model.
module tb_loopback_ctrl;
  import hc_pkg::*;

  localparam int unsigned DW  = 512;
  localparam int unsigned AW  = 42;
  localparam int unsigned FD  = 8;
  localparam int unsigned CAP = FD - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   num_lines;
  logic [AW-1:0] rd_base;
  logic [AW-1:0] wr_base;
  logic          busy;
  logic          done;
  logic          overflow_err;
  logic [31:0]   cycle_count;
  logic [31:0]   stall_count;

  loopback_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  loopback_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_lines    (num_lines),
    .rd_base      (rd_base),
    .wr_base      (wr_base),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .overflow_err (overflow_err),
    .cycle_count  (cycle_count),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Environment model: host memory returns reads in order; FIFO is a plain queue.
  logic [DW-1:0] fifo_q[$];
  int unsigned   rd_due_q[$];
  logic [AW-1:0] rd_addr_q[$];
  int unsigned   wr_due_q[$];

  int unsigned   cyc = 0;
  bit            enq_f, deq_f, reset_f;
  logic [DW-1:0] rsp_data_r;
  bit            start_req, reset_req, hold_rsp, stray_wr, rnd_bp, force_rd_af, force_wr_af, armed;
  int unsigned   rd_lat_max, wr_lat_max;
  int unsigned   n_rd, n_wr, n_ack, n_pop, n_lines, max_out;
  int unsigned   start_cyc, first_rd_cyc, done_cyc, last_ack_cyc;
  bit            done_seen;
  logic [AW-1:0] exp_rb, exp_wb;

  function automatic logic [DW-1:0] linedata(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    for (int i = 0; i < int'(DW / 32); i++)
      d[i*32 +: 32] = a[31:0] ^ {22'd0, a[AW-1:32]} ^ (32'(i) * 32'h9E37_79B9);
    return d;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic [AW-1:0] a;
    @(negedge clk);
    cyc++;
    // apply the FIFO/memory effects of the edge just passed
    if (reset_f) begin
      fifo_q.delete();
      rd_due_q.delete();
      rd_addr_q.delete();
      wr_due_q.delete();
    end else begin
      if (enq_f) fifo_q.push_back(rsp_data_r);
      if (deq_f && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        n_pop++;
      end
    end
    if (bus.rd_req_valid) begin
      a = exp_rb + AW'(n_rd);
      check("rd_addr", DW'(bus.rd_req_addr), DW'(a));
      if (n_rd == 0) first_rd_cyc = cyc;
      rd_addr_q.push_back(a);
      rd_due_q.push_back(cyc + $urandom_range(rd_lat_max, 0));
      n_rd++;
      if (n_rd - n_pop > max_out) max_out = n_rd - n_pop;
    end
    if (bus.wr_req_valid) begin
      check("wr_addr", DW'(bus.wr_req_addr), DW'(exp_wb + AW'(n_wr)));
      check("wr_data", bus.wr_req_data, linedata(exp_rb + AW'(n_wr)));
      wr_due_q.push_back(cyc + $urandom_range(wr_lat_max, 0));
      n_wr++;
    end
    if (armed && done && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
    // drive inputs for the next edge
    start = start_req;
    if (start_req) begin
      start_cyc = cyc;
      armed     = 1'b1;
    end
    start_req = 1'b0;
    reset     = reset_req;
    reset_f   = reset_req;
    reset_req = 1'b0;
    bus.fifo_not_full  = (fifo_q.size() < int'(CAP));
    bus.fifo_not_empty = (fifo_q.size() != 0);
    bus.fifo_deq_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    bus.rd_rsp_valid   = 1'b0;
    if (!hold_rsp && rd_due_q.size() > 0 && rd_due_q[0] <= cyc) begin
      bus.rd_rsp_valid = 1'b1;
      rsp_data_r = linedata(rd_addr_q.pop_front());
      void'(rd_due_q.pop_front());
    end
    bus.wr_rsp_valid = stray_wr;
    if (wr_due_q.size() > 0 && wr_due_q[0] <= cyc) begin
      bus.wr_rsp_valid = 1'b1;
      void'(wr_due_q.pop_front());
      n_ack++;
      last_ack_cyc = cyc;
    end
    bus.rd_almfull = force_rd_af || (rnd_bp && $urandom_range(3, 0) == 0);
    bus.wr_almfull = force_wr_af || (rnd_bp && $urandom_range(3, 0) == 0);
    #1;
    enq_f = bus.fifo_enq_en;
    deq_f = bus.fifo_deq_en;
  endtask

  task automatic begin_xfer(input int unsigned n, input logic [AW-1:0] rb, input logic [AW-1:0] wb);
    num_lines = n;
    rd_base   = rb;
    wr_base   = wb;
    exp_rb    = rb;
    exp_wb    = wb;
    n_lines   = n;
    n_rd = 0; n_wr = 0; n_ack = 0; n_pop = 0; max_out = 0;
    first_rd_cyc = 0; last_ack_cyc = 0;
    done_seen = 1'b0;
    armed     = 1'b0;
    start_req = 1'b1;
  endtask

  task automatic finish_xfer(input string tag, input int unsigned budget);
    for (int unsigned i = 0; i < budget && !done_seen; i++) cycle();
    check({tag, "_done_within_budget"}, DW'(done_seen), DW'(1'b1));
    check({tag, "_reads"},  DW'(n_rd),  DW'(n_lines));
    check({tag, "_writes"}, DW'(n_wr),  DW'(n_lines));
    check({tag, "_acks"},   DW'(n_ack), DW'(n_lines));
    check({tag, "_outstanding_le_cap"}, DW'(max_out <= CAP), DW'(1'b1));
    check({tag, "_done"}, DW'(done), DW'(1'b1));
    check({tag, "_busy"}, DW'(busy), DW'(1'b0));
    check({tag, "_overflow"}, DW'(overflow_err), DW'(1'b0));
    if (n_lines > 0) begin
      check({tag, "_done_after_last_ack"}, DW'(done_cyc - last_ack_cyc), DW'(1));
      if (!rnd_bp) check({tag, "_first_rd_latency"}, DW'(first_rd_cyc - start_cyc), DW'(2));
    end else begin
      check({tag, "_zero_done_latency"}, DW'(done_cyc - start_cyc), DW'(1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] top2;
    reset = 1'b1; start = 1'b0; num_lines = '0; rd_base = '0; wr_base = '0;
    bus.rd_almfull = 1'b0; bus.rd_rsp_valid = 1'b0; bus.fifo_not_full = 1'b1;
    bus.fifo_not_empty = 1'b0; bus.fifo_deq_data = '0; bus.wr_almfull = 1'b0;
    bus.wr_rsp_valid = 1'b0;
    rd_lat_max = 0; wr_lat_max = 0;
    exp_rb = '0; exp_wb = '0;

    reset_req = 1'b1; cycle();
    reset_req = 1'b1; cycle();
    cycle();
    check("rst_rd_valid", DW'(bus.rd_req_valid), '0);
    check("rst_wr_valid", DW'(bus.wr_req_valid), '0);
    check("rst_rd_addr",  DW'(bus.rd_req_addr), '0);
    check("rst_wr_addr",  DW'(bus.wr_req_addr), '0);
    check("rst_wr_data",  bus.wr_req_data, '0);
    check("rst_busy", DW'(busy), '0);
    check("rst_done", DW'(done), '0);
    check("rst_overflow", DW'(overflow_err), '0);
    check("rst_cycle_count", DW'(cycle_count), '0);
    check("rst_stall_count", DW'(stall_count), '0);

    // four lines, immediate echo
    begin_xfer(4, 42'h100, 42'h2000);
    finish_xfer("basic4", 60);

    // read responses withheld: credits cap outstanding reads at FIFO_DEPTH-1
    hold_rsp = 1'b1;
    begin_xfer(20, 42'h3000, 42'h4000);
    repeat (30) cycle();
    check("credit_cap_reads", DW'(n_rd), DW'(CAP));
    check("credit_cap_pops", DW'(n_pop), '0);
    hold_rsp = 1'b0;
    finish_xfer("credit20", 300);
`ifdef LOOPBACK_CTRL_STATS_EN
    check("stats_stall_nonzero", DW'(stall_count > 0), DW'(1'b1));
    check("stats_cycle_nonzero", DW'(cycle_count > 0), DW'(1'b1));
`else
    check("stats_cycle_tied", DW'(cycle_count), '0);
    check("stats_stall_tied", DW'(stall_count), '0);
`endif

    // write channel blocked: FIFO fills, reads stop, no overflow
    force_wr_af = 1'b1;
    begin_xfer(16, 42'h5000, 42'h6000);
    repeat (50) cycle();
    check("wr_block_reads", DW'(n_rd), DW'(CAP));
    check("wr_block_writes", DW'(n_wr), '0);
    check("wr_block_overflow", DW'(overflow_err), '0);
    force_wr_af = 1'b0;
    finish_xfer("wrblock16", 300);

    // zero lines
    begin_xfer(0, 42'h7000, 42'h8000);
    finish_xfer("zero", 10);

    // read address wraps at 2^ADDR_WIDTH
    top2 = '1;
    top2 = top2 - 42'd1;
    begin_xfer(4, top2, 42'h9000);
    finish_xfer("wrap", 60);

    // reset mid-run, stray write responses, then a fresh two-line transfer
    begin_xfer(8, 42'hA000, 42'hB000);
    for (int unsigned i = 0; i < 20 && n_rd < 3; i++) cycle();
    check("midrun_reads_seen", DW'(n_rd >= 3), DW'(1'b1));
    reset_req = 1'b1;
    cycle();
    cycle();
    check("midrun_rst_busy", DW'(busy), '0);
    check("midrun_rst_done", DW'(done), '0);
    check("midrun_rst_rd_valid", DW'(bus.rd_req_valid), '0);
    stray_wr = 1'b1;
    cycle();
    cycle();
    stray_wr = 1'b0;
    cycle();
    check("stray_busy", DW'(busy), '0);
    check("stray_done", DW'(done), '0);
    begin_xfer(2, 42'hC000, 42'hD000);
    finish_xfer("after_reset2", 60);

    // randomized transfers with backpressure and response latency
    rnd_bp = 1'b1; rd_lat_max = 4; wr_lat_max = 3;
    for (int k = 0; k < 3; k++) begin
      begin_xfer($urandom_range(30, 1), AW'({$urandom, $urandom}), AW'({$urandom, $urandom}));
      finish_xfer("random", 2000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
